// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl -- round sequencer for the AES datapath.
// Sequences AES-128/AES-256 full encryption, single-round ops (AESENC,
// AESENCLAST) and key-gen assist through IDLE -> SBOX -> ROUND -> DONE.
// Ports:
//   clk, rst           rising-edge clock, async active-high reset
//   start_i            request, accepted only while ready_o=1
//   opcode_i           operation (aes_pkg::opcode)
//   key_len_i          2'b00=AES-128, 2'b10=AES-256, others illegal
//   abort_i            synchronous abort of the running operation
//   ready_o / busy_o   idle / working
//   rnd_o              current round index
//   zero_rnd_o, final_rnd_o, mix_en_o, key_sel_o   aes_enc controls
//   key_sub_o          S-box input select (1=key word, 0=state)
//   key_step_o         key_gen advances one round key
//   rot_en_o           key_gen applies RotWord+Rcon this step
//   rcon_o             current Rcon (registered)
//   cipher_ready_o, key_ready_o   one-cycle completion pulses
//   err_o              one-cycle pulse after an illegal request

package aes_pkg;
  typedef enum logic [2:0] {
    NOOP            = 3'd0,
    AESENC          = 3'd1,
    AESENCLAST      = 3'd2,
    AESKEYGENASSIST = 3'd3,
    AESENCFULL      = 3'd4
  } opcode;
endpackage

module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned RND_W     = 4,
  parameter int unsigned NR_MAX    = 14,
  parameter logic [7:0]  RCON_INIT = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  opcode            opcode_i,
  input  logic [1:0]       key_len_i,
  input  logic             abort_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic [RND_W-1:0] rnd_o,
  output logic             zero_rnd_o,
  output logic             final_rnd_o,
  output logic             mix_en_o,
  output logic             key_sel_o,
  output logic             key_sub_o,
  output logic             key_step_o,
  output logic             rot_en_o,
  output logic [7:0]       rcon_o,
  output logic             cipher_ready_o,
  output logic             key_ready_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE, SBOX, ROUND, DONE} state_t;

  state_t           state_q, state_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic [7:0]       rcon_q, rcon_d;
  opcode            op_q, op_d;
  logic [1:0]       klen_q, klen_d;
  logic             err_q, err_d;

  logic             klen_ok;
  logic             full_req;
  logic             accept;
  logic [RND_W-1:0] nr;
  logic             last_rnd;
  logic             even_ge2;
  logic [7:0]       rcon_next;

  // AES-256 is only legal when the counter range was sized for it.
  assign klen_ok  = (key_len_i == 2'b00) || ((key_len_i == 2'b10) && (NR_MAX >= 14));
  assign full_req = start_i && (opcode_i == AESENCFULL);
  // An illegal key length blocks the accept entirely; only err_o reacts.
  assign accept   = (state_q == IDLE) && start_i && (opcode_i != NOOP) &&
                    !(full_req && !klen_ok);
  assign err_d    = (state_q == IDLE) && full_req && !klen_ok;

  assign nr        = (klen_q == 2'b10) ? RND_W'(14) : RND_W'(10);
  assign last_rnd  = (rnd_q == nr);
  assign even_ge2  = !rnd_q[0] && (rnd_q >= RND_W'(2));
  assign rcon_next = rcon_q[7] ? ({rcon_q[6:0], 1'b0} ^ 8'h1b) : {rcon_q[6:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      rcon_q  <= RCON_INIT;
      op_q    <= NOOP;
      klen_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      op_q    <= op_d;
      klen_q  <= klen_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rnd_d          = rnd_q;
    rcon_d         = rcon_q;
    op_d           = op_q;
    klen_d         = klen_q;
    zero_rnd_o     = 1'b0;
    final_rnd_o    = 1'b0;
    mix_en_o       = 1'b0;
    key_sel_o      = 1'b0;
    key_sub_o      = 1'b0;
    key_step_o     = 1'b0;
    rot_en_o       = 1'b0;
    cipher_ready_o = 1'b0;
    key_ready_o    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = opcode_i;
          klen_d = key_len_i;
          rcon_d = RCON_INIT;
          rnd_d  = '0;
          case (opcode_i)
            AESENCFULL: begin
              // Initial AddRoundKey happens in the accept cycle itself.
              zero_rnd_o = 1'b1;
              key_sel_o  = 1'b1;
              key_sub_o  = 1'b1;
              rnd_d      = RND_W'(1);
              state_d    = SBOX;
            end
            AESKEYGENASSIST: begin
              key_sub_o = 1'b1;
              state_d   = ROUND;
            end
            default: state_d = SBOX;
          endcase
        end
      end

      SBOX: begin
        if (op_q == AESENCFULL) begin
          key_step_o = 1'b1;
          // AES-256 applies RotWord+Rcon only on every second key step.
          rot_en_o   = (klen_q == 2'b00) || even_ge2;
          if (rot_en_o) rcon_d = rcon_next;
        end
        state_d = ROUND;
      end

      ROUND: begin
        if (op_q == AESENCFULL) begin
          zero_rnd_o  = 1'b1;
          key_sub_o   = 1'b1;
          mix_en_o    = !last_rnd;
          final_rnd_o = last_rnd;
          if (last_rnd) begin
            state_d = DONE;
          end else begin
            rnd_d   = rnd_q + RND_W'(1);
            state_d = SBOX;
          end
        end else begin
          mix_en_o    = (op_q == AESENC);
          final_rnd_o = (op_q == AESENCLAST);
          state_d     = DONE;
        end
      end

      DONE: begin
        key_ready_o    = (op_q == AESKEYGENASSIST);
        cipher_ready_o = (op_q != AESKEYGENASSIST);
        rnd_d          = '0;
        state_d        = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Abort overrides sequencing only; outputs of the current cycle
    // (including a DONE pulse) stay as decoded above.
    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      rnd_d   = '0;
      rcon_d  = RCON_INIT;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign busy_o  = !ready_o;
  assign rnd_o   = rnd_q;
  assign rcon_o  = rcon_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: stimulus pushes expected completion
// pulses, round controls and Rcon steps; a negedge monitor pops and compares.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  logic       clk, rst, start_i, abort_i;
  opcode      opcode_i;
  logic [1:0] key_len_i;
  logic       ready_o, busy_o, zero_rnd_o, final_rnd_o, mix_en_o, key_sel_o;
  logic       key_sub_o, key_step_o, rot_en_o, cipher_ready_o, key_ready_o, err_o;
  logic [3:0] rnd_o;
  logic [7:0] rcon_o;

  aes_round_ctrl #(.RND_W(4), .NR_MAX(14), .RCON_INIT(8'h01)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .opcode_i(opcode_i),
    .key_len_i(key_len_i), .abort_i(abort_i), .ready_o(ready_o),
    .busy_o(busy_o), .rnd_o(rnd_o), .zero_rnd_o(zero_rnd_o),
    .final_rnd_o(final_rnd_o), .mix_en_o(mix_en_o), .key_sel_o(key_sel_o),
    .key_sub_o(key_sub_o), .key_step_o(key_step_o), .rot_en_o(rot_en_o),
    .rcon_o(rcon_o), .cipher_ready_o(cipher_ready_o),
    .key_ready_o(key_ready_o), .err_o(err_o)
  );

  typedef struct {int kind; int cyc;} done_t;          // 0 cipher, 1 key, 2 err
  typedef struct {logic [7:0] rcon; int rnd;} rcon_t;
  typedef struct {int rnd; logic mix; logic fin;} rnd_t;

  done_t done_q[$];
  rcon_t rcon_q[$];
  rnd_t  round_q[$];

  logic [7:0] RC_TAB [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [23:0] RESET_OUTS = {1'b1, 1'b0, 4'd0, 7'd0, 8'h01, 3'd0};

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] outs();
    return {ready_o, busy_o, rnd_o, zero_rnd_o, final_rnd_o, mix_en_o, key_sel_o,
            key_sub_o, key_step_o, rot_en_o, rcon_o, cipher_ready_o, key_ready_o, err_o};
  endfunction

  task automatic exp_done(input int kind, input int c);
    done_t d;
    d.kind = kind; d.cyc = c;
    done_q.push_back(d);
  endtask

  task automatic exp_round(input int r, input logic mix, input logic fin);
    rnd_t e;
    e.rnd = r; e.mix = mix; e.fin = fin;
    round_q.push_back(e);
  endtask

  task automatic exp_rcon(input logic [7:0] rc, input int r);
    rcon_t e;
    e.rcon = rc; e.rnd = r;
    rcon_q.push_back(e);
  endtask

  // Full-encryption expectations up to round 'upto'; completion only if it runs to Nr.
  task automatic push_full(input logic [1:0] kl, input int acc, input int upto);
    int nr;
    int k;
    nr = (kl == 2'b10) ? 14 : 10;
    k = 0;
    for (int r = 1; r <= upto; r++) begin
      exp_round(r, r != nr, r == nr);
      if (kl == 2'b00 || (r % 2) == 0) begin
        exp_rcon(RC_TAB[k], r);
        k++;
      end
    end
    if (upto == nr) exp_done(0, acc + 2 * nr + 1);
  endtask

  // Called at a negedge; the current cycle becomes the accept cycle.
  task automatic run_op(input opcode o, input logic [1:0] kl, input logic ab);
    int acc;
    logic [2:0] mealy;
    acc = cyc;
    start_i = 1'b1; opcode_i = o; key_len_i = kl; abort_i = ab;
    mealy = 3'b000;
    case (o)
      AESENCFULL: begin push_full(kl, acc, (kl == 2'b10) ? 14 : 10); mealy = 3'b111; end
      AESENC: begin exp_round(0, 1'b1, 1'b0); exp_done(0, acc + 3); end
      AESENCLAST: begin exp_round(0, 1'b0, 1'b1); exp_done(0, acc + 3); end
      AESKEYGENASSIST: begin exp_done(1, acc + 2); mealy = 3'b001; end
      default: ;
    endcase
    #1;
    chk("accept_ctrl", {zero_rnd_o, key_sel_o, key_sub_o}, mealy);
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0; opcode_i = NOOP;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((done_q.size() + rcon_q.size() + round_q.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", done_q.size() + rcon_q.size() + round_q.size(), 0);
  endtask

  // Monitor: every Moore event the DUT presents must match the queue head.
  always @(negedge clk) begin
    done_t d;
    rcon_t rc;
    rnd_t  rr;
    if (!rst) begin
      if (cipher_ready_o || key_ready_o || err_o) begin
        chk("pulse_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) begin
          d = done_q.pop_front();
          chk("pulse_kind", {cipher_ready_o, key_ready_o, err_o},
              (d.kind == 0) ? 3'b100 : (d.kind == 1) ? 3'b010 : 3'b001);
          chk("pulse_cycle", cyc, d.cyc);
        end
      end
      if (rot_en_o) begin
        chk("rot_expected", rcon_q.size() != 0, 1);
        if (rcon_q.size() != 0) begin
          rc = rcon_q.pop_front();
          chk("rcon", rcon_o, rc.rcon);
          chk("rot_rnd", rnd_o, rc.rnd);
          chk("rot_key_step", key_step_o, 1);
        end
      end
      if (mix_en_o || final_rnd_o) begin
        chk("round_expected", round_q.size() != 0, 1);
        if (round_q.size() != 0) begin
          rr = round_q.pop_front();
          chk("round_rnd", rnd_o, rr.rnd);
          chk("round_mix_fin", {mix_en_o, final_rnd_o}, {rr.mix, rr.fin});
        end
      end
    end
  end

  initial begin
    int n0;
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; opcode_i = NOOP; key_len_i = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), RESET_OUTS);
    rst = 1'b0;
    @(negedge clk);

    // AES-128 full, then key-gen assist (Rcon must restart at 01)
    run_op(AESENCFULL, 2'b00, 1'b0);
    wait_drain(60);
    @(negedge clk);
    run_op(AESKEYGENASSIST, 2'b00, 1'b0);
    chk("keygen_rcon", rcon_o, 8'h01);
    wait_drain(10);
    chk("keygen_rcon_end", rcon_o, 8'h01);
    @(negedge clk);

    // AES-256 full
    run_op(AESENCFULL, 2'b10, 1'b0);
    wait_drain(80);
    @(negedge clk);

    // Single rounds; abort in IDLE must not block the accept
    run_op(AESENC, 2'b00, 1'b1);
    wait_drain(10);
    @(negedge clk);
    run_op(AESENCLAST, 2'b00, 1'b0);
    wait_drain(10);
    @(negedge clk);

    // NOOP start is ignored
    start_i = 1'b1; opcode_i = NOOP;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("noop_ready", ready_o, 1);
    end
    start_i = 1'b0;
    @(negedge clk);

    // start held high: second accept in the cycle after DONE
    n0 = cyc;
    start_i = 1'b1; opcode_i = AESENCFULL; key_len_i = 2'b00;
    push_full(2'b00, n0, 10);
    push_full(2'b00, n0 + 22, 10);
    while (cyc < n0 + 23) @(negedge clk);
    start_i = 1'b0; opcode_i = NOOP;
    wait_drain(60);
    @(negedge clk);

    // Abort in round 5 of AES-128, then a clean run
    n0 = cyc;
    start_i = 1'b1; opcode_i = AESENCFULL; key_len_i = 2'b00;
    push_full(2'b00, n0, 5);
    @(negedge clk);
    start_i = 1'b0; opcode_i = NOOP;
    while (cyc < n0 + 10) @(negedge clk);
    chk("abort_at_rnd", rnd_o, 5);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_idle", {ready_o, rnd_o, rcon_o}, {1'b1, 4'd0, 8'h01});
    run_op(AESENCFULL, 2'b00, 1'b0);
    wait_drain(60);
    @(negedge clk);

    // Illegal key length: err pulse, never busy
    n0 = cyc;
    start_i = 1'b1; opcode_i = AESENCFULL; key_len_i = 2'b01;
    exp_done(2, n0 + 1);
    #1;
    chk("illegal_accept_ctrl", {zero_rnd_o, key_sel_o, key_sub_o}, 3'b000);
    @(negedge clk);
    start_i = 1'b0; opcode_i = NOOP; key_len_i = 2'b00;
    chk("illegal_ready", ready_o, 1);
    @(negedge clk);
    chk("illegal_ready2", ready_o, 1);
    wait_drain(5);

    // Async reset mid-round: outputs return before any clock edge
    run_op(AESENCFULL, 2'b00, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outs", outs(), RESET_OUTS);
    done_q.delete(); rcon_q.delete(); round_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_outs", outs(), RESET_OUTS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
